restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 128 ++++++++++++
 tb/tb_restoring_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Restoring divider: unsigned WIDTH-bit division, one quotient bit per cycle.
//
// Ports:
//   CLK    rising-edge clock
//   RST    synchronous active-high reset
//   START  begin a division (accepted only when idle or finishing)
//   A, B   dividend / divisor, latched on an accepted START
//   Q, R   registered quotient / remainder of the last completed division
//   BUSY   high while iterating
//   DONE   one-cycle pulse when Q/R/DZ carry a new result
//   DZ     registered divide-by-zero flag for the current result
module restoring_divider #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             BUSY,
   output logic             DONE,
   output logic             DZ
);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   localparam logic [WIDTH-1:0] LastCnt = WIDTH'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   prem_q, prem_d;   // partial remainder, one guard bit
   logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend, shifted out MSB-first
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] quo_q, quo_d;     // quotient under construction
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             dz_q, dz_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      quo_d   = quo_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;

      // A kept partial remainder is always < divisor, so its top bit is zero
      // and dropping it on the shift loses nothing.
      shifted = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
      diff    = shifted - {1'b0, dvs_q};

      unique case (state_q)
         StRun: begin
            // Sign bit of the trial difference decides keep vs. restore.
            prem_d   = diff[WIDTH] ? shifted : diff;
            quo_d    = quo_q << 1;
            quo_d[0] = ~diff[WIDTH];
            dvd_d    = dvd_q << 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
               state_d = StFin;
               q_d     = quo_d;
               r_d     = prem_d[WIDTH-1:0];
               dz_d    = 1'b0;
            end
         end
         StIdle, StFin: begin
            if (START) begin
               dvd_d  = A;
               dvs_d  = B;
               prem_d = '0;
               cnt_d  = '0;
               quo_d  = '0;
               if (B != '0) begin
                  state_d = StRun;
               end else begin
                  state_d = StFin;
                  q_d     = '1;
                  r_d     = A;
                  dz_d    = 1'b1;
               end
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         prem_q  <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         quo_q   <= quo_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dz_q    <= dz_d;
      end
   end

   assign Q    = q_q;
   assign R    = r_q;
   assign DZ   = dz_q;
   assign BUSY = (state_q == StRun);
   assign DONE = (state_q == StFin);

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases, an exhaustive
// operand sweep and randomized traffic, checked against an arithmetic model.
module tb_restoring_divider;

   localparam int unsigned WIDTH = 4;

   logic             CLK;
   logic             RST;
   logic             START;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] R;
   logic             BUSY;
   logic             DONE;
   logic             DZ;

   int unsigned n_vec;
   int unsigned n_err;

   // Last result the outputs must hold until the next one arrives.
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] prev_r;
   logic             prev_dz;

   restoring_divider #(.WIDTH(WIDTH)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .A     (A),
      .B     (B),
      .Q     (Q),
      .R     (R),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .DZ    (DZ)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                   output logic dz);
      int unsigned ai;
      int unsigned bi;
      ai = 32'(a);
      bi = 32'(b);
      if (bi == 0) begin
         q  = '1;
         r  = a;
         dz = 1'b1;
      end else begin
         q  = WIDTH'(ai / bi);
         r  = WIDTH'(ai % bi);
         dz = 1'b0;
      end
   endfunction

   // Called at a negedge in IDLE or FIN; returns at the negedge of the DONE cycle.
   task automatic do_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit poke);
      logic [WIDTH-1:0] eq;
      logic [WIDTH-1:0] er;
      logic             edz;
      ref_div(a, b, eq, er, edz);
      START = 1'b1;
      A     = a;
      B     = b;
      @(negedge CLK);
      START = 1'b0;
      if (b != '0) begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            START = 1'b0;
            check("busy_run", 32'(BUSY), 1);
            check("done_run", 32'(DONE), 0);
            check("q_hold", 32'(Q), 32'(prev_q));
            check("r_hold", 32'(R), 32'(prev_r));
            check("dz_hold", 32'(DZ), 32'(prev_dz));
            if (poke && i == 1) begin
               START = 1'b1;
               A     = '0;
               B     = '0;
            end
            @(negedge CLK);
         end
         START = 1'b0;
      end
      check("done", 32'(DONE), 1);
      check("busy_fin", 32'(BUSY), 0);
      check("q", 32'(Q), 32'(eq));
      check("r", 32'(R), 32'(er));
      check("dz", 32'(DZ), 32'(edz));
      prev_q  = eq;
      prev_r  = er;
      prev_dz = edz;
   endtask

   task automatic go_idle();
      START = 1'b0;
      @(negedge CLK);
      check("done_idle", 32'(DONE), 0);
      check("busy_idle", 32'(BUSY), 0);
      check("q_idle", 32'(Q), 32'(prev_q));
      check("r_idle", 32'(R), 32'(prev_r));
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      RST     = 1'b1;
      START   = 1'b0;
      A       = '0;
      B       = '0;
      prev_q  = '0;
      prev_r  = '0;
      prev_dz = 1'b0;

      repeat (2) @(negedge CLK);
      check("rst_q", 32'(Q), 0);
      check("rst_r", 32'(R), 0);
      check("rst_busy", 32'(BUSY), 0);
      check("rst_done", 32'(DONE), 0);
      check("rst_dz", 32'(DZ), 0);

      // Reset beats START at the same edge.
      START = 1'b1;
      A     = 4'd5;
      B     = 4'd0;
      @(negedge CLK);
      check("rst_start_done", 32'(DONE), 0);
      check("rst_start_dz", 32'(DZ), 0);
      RST   = 1'b0;
      START = 1'b0;
      @(negedge CLK);
      check("rst_start_idle", 32'(DONE), 0);

      // Directed cases.
      do_div(4'd13, 4'd4, 1'b0);
      go_idle();
      do_div(4'd15, 4'd1, 1'b0);
      go_idle();
      do_div(4'd3, 4'd7, 1'b0);
      go_idle();
      do_div(4'd5, 4'd0, 1'b0);
      go_idle();
      do_div(4'd6, 4'd5, 1'b0);
      go_idle();
      do_div(4'd9, 4'd2, 1'b1);
      do_div(4'd14, 4'd3, 1'b0);
      go_idle();

      // Reset in the second RUN cycle aborts the division.
      START = 1'b1;
      A     = 4'd9;
      B     = 4'd2;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("abort_q", 32'(Q), 0);
      check("abort_r", 32'(R), 0);
      check("abort_busy", 32'(BUSY), 0);
      check("abort_done", 32'(DONE), 0);
      check("abort_dz", 32'(DZ), 0);
      prev_q  = '0;
      prev_r  = '0;
      prev_dz = 1'b0;
      for (int i = 0; i < 2 * int'(WIDTH); i++) begin
         @(negedge CLK);
         check("abort_no_done", 32'(DONE), 0);
         check("abort_no_busy", 32'(BUSY), 0);
      end

      // Exhaustive sweep, alternating idle gaps and back-to-back starts.
      for (int ai = 0; ai < (1 << WIDTH); ai++) begin
         for (int bi = 0; bi < (1 << WIDTH); bi++) begin
            do_div(WIDTH'(ai), WIDTH'(bi), 1'b0);
            if (bi[0]) go_idle();
         end
      end
      go_idle();

      // Randomized traffic with ignored mid-run STARTs and random gaps.
      for (int n = 0; n < 300; n++) begin
         logic [WIDTH-1:0] ra;
         logic [WIDTH-1:0] rb;
         int unsigned      gaps;
         ra = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
         rb = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
         do_div(ra, rb, ($urandom_range(0, 3) == 0));
         gaps = $urandom_range(0, 2);
         for (int g = 0; g < int'(gaps); g++) go_idle();
      end
      go_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
